// File: rtl/id_ex_shift_stage.sv
// ID/EX pipeline register feeding the execute-stage shifter.
// Decodes RV32I shifts into registered shifter controls and counts inserted bubbles.
module id_ex_shift_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic             in_is_op,
  input  logic             in_is_opimm,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_shamt,
  output logic [1:0]       ex_alusel,
  output logic             ex_is_shift,
  output logic             ex_illegal,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] SEL_SLL  = 2'b00;
  localparam logic [1:0] SEL_SRL  = 2'b01;
  localparam logic [1:0] SEL_SRA  = 2'b10;
  localparam logic [1:0] SEL_PASS = 2'b11;

  logic       shift_funct3;
  logic       shift_candidate;
  logic [1:0] dec_alusel;
  logic       dec_is_shift;
  logic       dec_illegal;
  logic [4:0] dec_shamt;
  logic       dec_reg_write;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    shift_funct3    = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    shift_candidate = (in_is_op || in_is_opimm) && shift_funct3;
    dec_alusel      = SEL_PASS;
    dec_is_shift    = 1'b0;
    dec_illegal     = 1'b0;
    dec_shamt       = 5'd0;
    dec_reg_write   = in_reg_write;
    if (shift_candidate) begin
      dec_is_shift = 1'b1;
      if (in_funct3 == 3'b001 && in_funct7 == 7'b0000000)
        dec_alusel = SEL_SLL;
      else if (in_funct3 == 3'b101 && in_funct7 == 7'b0000000)
        dec_alusel = SEL_SRL;
      else if (in_funct3 == 3'b101 && in_funct7 == 7'b0100000)
        dec_alusel = SEL_SRA;
      else begin
        dec_is_shift  = 1'b0;
        dec_illegal   = 1'b1;
        dec_reg_write = 1'b0;
      end
      // OP-IMM wins when both opcode flags are set, so the immediate supplies shamt
      if (dec_is_shift)
        dec_shamt = in_is_opimm ? in_imm[4:0] : in_rs2_data[4:0];
    end
  end

  // Counter sticks at all-ones instead of wrapping
  assign cnt_next = (bubble_cnt == {CNT_W{1'b1}}) ? bubble_cnt : bubble_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_shamt     <= '0;
      ex_alusel    <= SEL_PASS;
      ex_is_shift  <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      bubble_cnt   <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_a         <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_shamt     <= '0;
      ex_alusel    <= SEL_PASS;
      ex_is_shift  <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      bubble_cnt   <= cnt_next;
    end else if (!stall) begin
      ex_valid     <= 1'b1;
      ex_pc        <= in_pc;
      ex_a         <= in_rs1_data;
      ex_rs2_data  <= in_rs2_data;
      ex_imm       <= in_imm;
      ex_shamt     <= dec_shamt;
      ex_alusel    <= dec_alusel;
      ex_is_shift  <= dec_is_shift;
      ex_illegal   <= dec_illegal;
      ex_rd        <= in_rd;
      ex_reg_write <= dec_reg_write;
    end
  end

endmodule

// File: tb/tb_id_ex_shift_stage.sv
// Self-checking bench for id_ex_shift_stage: directed steps then random traffic
// compared against an instruction-level reference model.
module tb_id_ex_shift_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        in_is_op, in_is_opimm, in_reg_write;
  logic [4:0]  in_rd;

  logic        ex_valid, ex_is_shift, ex_illegal, ex_reg_write;
  logic [31:0] ex_pc, ex_a, ex_rs2_data, ex_imm;
  logic [4:0]  ex_shamt, ex_rd;
  logic [1:0]  ex_alusel;
  logic [15:0] bubble_cnt;

  logic        n_valid, n_is_shift, n_illegal, n_reg_write;
  logic [31:0] n_pc, n_a, n_rs2_data, n_imm;
  logic [4:0]  n_shamt, n_rd;
  logic [1:0]  n_alusel;
  logic [1:0]  n_bubble_cnt;

  int checks = 0;
  int errors = 0;

  logic        m_valid, m_is_shift, m_illegal, m_reg_write;
  logic [31:0] m_pc, m_a, m_rs2, m_imm;
  int          m_shamt, m_alusel, m_rd;
  int          m_cnt, m_cnt2;

  always #5 clk = ~clk;

  id_ex_shift_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_is_op(in_is_op), .in_is_opimm(in_is_opimm),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_shamt(ex_shamt), .ex_alusel(ex_alusel), .ex_is_shift(ex_is_shift), .ex_illegal(ex_illegal),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance to exercise saturation quickly
  id_ex_shift_stage #(.XLEN(32), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_is_op(in_is_op), .in_is_opimm(in_is_opimm),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .ex_valid(n_valid), .ex_pc(n_pc), .ex_a(n_a), .ex_rs2_data(n_rs2_data), .ex_imm(n_imm),
    .ex_shamt(n_shamt), .ex_alusel(n_alusel), .ex_is_shift(n_is_shift), .ex_illegal(n_illegal),
    .ex_rd(n_rd), .ex_reg_write(n_reg_write), .bubble_cnt(n_bubble_cnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelBubble();
    m_valid = 1'b0; m_pc = 0; m_a = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    m_shamt = 0; m_alusel = 3; m_is_shift = 1'b0; m_illegal = 1'b0; m_reg_write = 1'b0;
  endtask

  task automatic modelCount();
    if (m_cnt < 65535) m_cnt++;
    if (m_cnt2 < 3) m_cnt2++;
  endtask

  // Instruction-level view: name the instruction, then derive the shifter controls
  task automatic modelLoad();
    string kind;
    bit    isShiftOpcode;
    int    f3, f7;
    f3 = int'(in_funct3);
    f7 = int'(in_funct7);
    isShiftOpcode = in_is_op || in_is_opimm;
    kind = "other";
    if (isShiftOpcode && f3 == 1) kind = (f7 == 0) ? "sll" : "bad";
    else if (isShiftOpcode && f3 == 5) kind = (f7 == 0) ? "srl" : (f7 == 32) ? "sra" : "bad";
    m_valid = 1'b1; m_pc = in_pc; m_a = in_rs1_data; m_rs2 = in_rs2_data; m_imm = in_imm;
    m_rd = int'(in_rd);
    m_is_shift = (kind == "sll" || kind == "srl" || kind == "sra");
    m_illegal = (kind == "bad");
    m_reg_write = in_reg_write && !m_illegal;
    m_alusel = (kind == "sll") ? 0 : (kind == "srl") ? 1 : (kind == "sra") ? 2 : 3;
    m_shamt = !m_is_shift ? 0 : in_is_opimm ? int'(in_imm % 32) : int'(in_rs2_data % 32);
  endtask

  task automatic modelStep();
    if (rst) begin
      modelBubble(); m_cnt = 0; m_cnt2 = 0;
    end else if (flush) begin
      modelBubble(); modelCount();
    end else if (stall) begin
    end else if (!in_valid) begin
      modelBubble(); modelCount();
    end else begin
      modelLoad();
    end
  endtask

  task automatic checkOutput();
    checkVal("ex_valid", 32'(ex_valid), 32'(m_valid));
    checkVal("ex_pc", ex_pc, m_pc);
    checkVal("ex_a", ex_a, m_a);
    checkVal("ex_rs2_data", ex_rs2_data, m_rs2);
    checkVal("ex_imm", ex_imm, m_imm);
    checkVal("ex_shamt", 32'(ex_shamt), 32'(m_shamt));
    checkVal("ex_alusel", 32'(ex_alusel), 32'(m_alusel));
    checkVal("ex_is_shift", 32'(ex_is_shift), 32'(m_is_shift));
    checkVal("ex_illegal", 32'(ex_illegal), 32'(m_illegal));
    checkVal("ex_rd", 32'(ex_rd), 32'(m_rd));
    checkVal("ex_reg_write", 32'(ex_reg_write), 32'(m_reg_write));
    checkVal("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
    checkVal("bubble_cnt_w2", 32'(n_bubble_cnt), 32'(m_cnt2));
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic setInstr(input logic v, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic [2:0] f3,
                          input logic [6:0] f7, input logic op, input logic opimm,
                          input logic [4:0] rd, input logic rw);
    in_valid = v; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    in_funct3 = f3; in_funct7 = f7; in_is_op = op; in_is_opimm = opimm;
    in_rd = rd; in_reg_write = rw;
  endtask

  task automatic randomInstr();
    int pick;
    pick = int'($urandom_range(0, 3));
    setInstr(1'($urandom_range(0, 4) != 0), $urandom, $urandom, $urandom, $urandom,
             (pick == 0) ? 3'($urandom_range(0, 7)) : (pick == 1) ? 3'b001 : 3'b101,
             (pick == 3) ? 7'($urandom_range(0, 127)) : ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)));
  endtask

  initial begin
    int satSeq[5];
    satSeq = '{1, 2, 3, 3, 3};
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    setInstr(1'b0, 0, 0, 0, 0, 3'b0, 7'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    m_cnt = 0; m_cnt2 = 0; modelBubble();

    applyStimulus();
    applyStimulus();
    checkVal("reset_alusel", 32'(ex_alusel), 32'h3);
    checkVal("reset_cnt", 32'(bubble_cnt), 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkVal("idle_cnt", 32'(bubble_cnt), 32'(i + 1));
      checkVal("sat_cnt_w2", 32'(n_bubble_cnt), 32'(satSeq[i]));
    end

    setInstr(1'b1, 32'h100, 32'h80000000, 32'h0, 32'h405, 3'b101, 7'b0100000, 1'b0, 1'b1, 5'd7, 1'b1);
    applyStimulus();
    checkVal("srai_alusel", 32'(ex_alusel), 32'h2);
    checkVal("srai_shamt", 32'(ex_shamt), 32'd5);
    checkVal("srai_a", ex_a, 32'h80000000);
    checkVal("srai_is_shift", 32'(ex_is_shift), 32'h1);

    setInstr(1'b1, 32'h104, 32'h1, 32'hFFFFFFE3, 32'h0, 3'b001, 7'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    applyStimulus();
    checkVal("sll_shamt", 32'(ex_shamt), 32'd3);
    checkVal("sll_alusel", 32'(ex_alusel), 32'h0);
    setInstr(1'b1, 32'h108, 32'h5, 32'hFFFFFFE3, 32'h0, 3'b000, 7'b0, 1'b1, 1'b0, 5'd4, 1'b1);
    applyStimulus();
    checkVal("add_alusel", 32'(ex_alusel), 32'h3);
    checkVal("add_shamt", 32'(ex_shamt), 32'd0);
    checkVal("add_is_shift", 32'(ex_is_shift), 32'h0);

    setInstr(1'b1, 32'h10C, 32'h5, 32'h0, 32'h21, 3'b001, 7'b0000001, 1'b0, 1'b1, 5'd9, 1'b1);
    applyStimulus();
    checkVal("slli_bad_illegal", 32'(ex_illegal), 32'h1);
    checkVal("slli_bad_reg_write", 32'(ex_reg_write), 32'h0);
    checkVal("slli_bad_valid", 32'(ex_valid), 32'h1);

    setInstr(1'b1, 32'h110, 32'hF0F0F0F0, 32'h0000000C, 32'h0, 3'b101, 7'b0, 1'b1, 1'b0, 5'd10, 1'b1);
    applyStimulus();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomInstr();
      applyStimulus();
      checkVal("stall_pc", ex_pc, 32'h110);
      checkVal("stall_shamt", 32'(ex_shamt), 32'd12);
    end
    flush = 1'b1;
    applyStimulus();
    checkVal("flush_stall_valid", 32'(ex_valid), 32'h0);
    flush = 1'b0; stall = 1'b0;

    // Both opcode flags set: immediate supplies the shift amount
    setInstr(1'b1, 32'h114, 32'h7, 32'h2, 32'h9, 3'b101, 7'b0, 1'b1, 1'b1, 5'd11, 1'b1);
    applyStimulus();
    checkVal("both_flags_shamt", 32'(ex_shamt), 32'd9);

    stall = 1'b1; flush = 1'b1; rst = 1'b1;
    applyStimulus();
    checkVal("rst_over_stall_cnt", 32'(bubble_cnt), 32'h0);
    rst = 1'b0; flush = 1'b0; stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      randomInstr();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_shift_stage.md
Name: id_ex_shift_stage

Overview:
- ID/EX pipeline register for the integer datapath; sits directly upstream of the execute-stage shifter.
- Captures decoded operands and produces registered shifter controls: operand `ex_a`, `ex_shamt`, `ex_alusel`.
- Decodes RV32I shift instructions (SLL/SLLI/SRL/SRLI/SRA/SRAI) from funct3/funct7 and flags malformed immediate shifts.
- Handles stall, flush and bubble insertion, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- stall  input  1  hold all EX registers this cycle
- flush  input  1  replace EX contents with a bubble
- in_valid  input  1  decode stage holds a real instruction
- in_pc  input  XLEN  instruction PC
- in_rs1_data  input  XLEN  rs1 operand
- in_rs2_data  input  XLEN  rs2 operand
- in_imm  input  XLEN  sign-extended immediate
- in_funct3  input  3  instr[14:12]
- in_funct7  input  7  instr[31:25]; imm[11:5] for OP-IMM
- in_is_op  input  1  opcode OP (0110011)
- in_is_opimm  input  1  opcode OP-IMM (0010011)
- in_rd  input  5  destination register
- in_reg_write  input  1  writes rd
- ex_valid  output  1  EX holds a real instruction
- ex_pc  output  XLEN  registered PC
- ex_a  output  XLEN  shifter/ALU operand A (rs1)
- ex_rs2_data  output  XLEN  registered rs2
- ex_imm  output  XLEN  registered immediate
- ex_shamt  output  5  shift amount
- ex_alusel  output  2  shifter select: 00 SLL, 01 SRL, 10 SRA, 11 pass-through
- ex_is_shift  output  1  EX instruction is a valid shift
- ex_illegal  output  1  malformed shift encoding
- ex_rd  output  5  registered rd
- ex_reg_write  output  1  registered write enable
- bubble_cnt  output  CNT_W  saturating count of bubbles captured

Behaviour:
- All outputs are registered and update only on rising clk. Latency is one cycle from inputs to outputs.
- Priority order: rst > flush > stall > normal load.
- **rst:** every output is 0, except `ex_alusel`, which is 2'b11.
- **Bubble value:**
  - `ex_valid`, `ex_reg_write`, `ex_is_shift`, `ex_illegal` = 0.
  - `ex_alusel` = 11.
  - All data fields and `ex_rd` = 0.
- **flush=1:** load the bubble regardless of stall; increment `bubble_cnt`.
- **stall=1 (flush=0):** hold every output, including `bubble_cnt`.
- **Normal load with in_valid=0:** load the bubble; increment `bubble_cnt`.
- **Normal load with in_valid=1:**
  - Copy pc, rs1, rs2, imm and rd.
  - `ex_valid` = 1.
- **Shift decode.** A shift is `(in_is_op | in_is_opimm) & funct3 ∈ {001, 101}`.
  - funct3=001 with funct7=0000000 → SLL, alusel 00.
  - funct3=101 with funct7=0000000 → SRL, alusel 01.
  - funct3=101 with funct7=0100000 → SRA, alusel 10.
  - Any other funct7 with a shift funct3 → `ex_illegal`=1, `ex_is_shift`=0, `ex_reg_write`=0, alusel 11.
  - Valid shift → `ex_is_shift`=1, `ex_illegal`=0, `ex_reg_write`=`in_reg_write`.
- **Shift amount.**
  - `ex_shamt` = `in_imm[4:0]` when `in_is_opimm`, else `in_rs2_data[4:0]`.
  - Upper rs2 bits are ignored.
  - `ex_shamt` is 0 for non-shifts.
- **Non-shift valid instruction:** alusel 11, `ex_is_shift`=0, `ex_illegal`=0, `ex_reg_write`=`in_reg_write`.
- **in_is_op and in_is_opimm both 1:** input error; treat as OP-IMM.
- **`bubble_cnt`:** saturates at 2^CNT_W−1 and does not wrap.
- **rst mid-stall or mid-flush:** reset wins; outputs take reset values the same edge.

Test Plan:
1. rst=1 for 2 cycles, then release with in_valid=0 → all outputs 0 and `ex_alusel`=11 during reset; `bubble_cnt`=1 after the first post-reset edge.
2. SRAI: in_is_opimm=1, funct3=101, funct7=0100000, in_imm=0x405, rs1=0x80000000 → next cycle `ex_alusel`=10, `ex_shamt`=5, `ex_a`=0x80000000, `ex_is_shift`=1.
3. SLL R-type with rs2=0xFFFFFFE3 → `ex_shamt`=3, `ex_alusel`=00. Then ADD (funct3=000) → `ex_alusel`=11, `ex_shamt`=0, `ex_is_shift`=0.
4. SLLI with funct7=0000001, in_reg_write=1 → `ex_illegal`=1, `ex_reg_write`=0, `ex_valid`=1.
5. Load SRL, then 3 cycles stall=1 with changing inputs → outputs frozen and `bubble_cnt` unchanged. Then stall=1 and flush=1 together → bubble loaded, `bubble_cnt`+1.
6. With CNT_W=2, in_valid=0 for 5 cycles → `bubble_cnt` goes 1,2,3,3,3.
